arp_wavetable_sequencer: RTL and testbench
==========================================

// Module: arp_wavetable_sequencer
// PURPOSE
//   Sequencer for the sine-wavetable audio path. It steps the BRAM read
//   address at a rate set by SW, captures each BRAM sample for the PWM
//   stage, and, when the arpeggio is enabled, cycles through four notes.
//   It sits between the debounced arp toggle / switches and the BRAM -> PWM
//   datapath in the top level.
// PARAMETERS
//   ADDR_W       8           wavetable address width (256 entries)
//   DATA_W       11          sample width (BRAM douta / PWM input)
//   BASE_OFFSET  746         constant added to SW to form the root step period
//   NOTE_HOLD    50_000_000  clocks per arpeggio note (0.5 s at 100 MHz); >= 2
//   BRAM_LAT     1           BRAM read latency in clocks; 1..4
// PORTS
//   CLK100MHZ    in   1       system clock, 100 MHz
//   CPU_RESETN   in   1       asynchronous active-low reset
//   arp_en       in   1       level; 1 = arpeggiate, 0 = hold root note
//   sw           in   8       pitch select; a larger value gives a lower pitch
//   bram_en      out  1       BRAM read enable, one-cycle pulse per step
//   bram_addr    out  ADDR_W  BRAM read address
//   bram_dout    in   DATA_W  BRAM read data, valid BRAM_LAT clocks after bram_en
//   sample       out  DATA_W  held sample to PWM
//   sample_valid out  1       one-cycle pulse when sample updates
//   note         out  2       current note index (drives LED[1:0])
// BEHAVIOUR
//   Reset (asynchronous, CPU_RESETN=0):
//   - Outputs bram_en, bram_addr, sample, sample_valid and note all go to 0.
//   - The step counter, note timer and latency pipe are cleared.
//   Root period:
//   - div_base = BASE_OFFSET + sw, a 10-bit unsigned value (746..1001). It must not be truncated.
//   Step period per note, products 18-bit, results floored:
//   - note0: P = div_base (root).
//   - note1: P = (div_base*205)>>8 (major third, ~x5/4 freq).
//   - note2: P = (div_base*171)>>8 (fifth, ~x3/2).
//   - note3: P = div_base>>1 (octave).
//   Step timer:
//   - step_cnt counts 0..P_lat-1. P_lat is P latched when step_cnt wraps to 0.
//   - Changes to sw or note take effect at the next step boundary, never mid-step.
//   - On the clock edge where step_cnt == P_lat-1:
//     - bram_addr <= bram_addr+1. The address wraps 255 -> 0.
//     - bram_en <= 1 for exactly one cycle.
//   Sample capture:
//   - bram_en is high in cycle k. bram_dout is valid in cycle k+BRAM_LAT.
//   - sample <= bram_dout at the end of cycle k+BRAM_LAT.
//   - sample_valid is high in cycle k+BRAM_LAT+1 only.
//   - sample holds its value between updates.
//   - Minimum P (373) > BRAM_LAT+1, so reads never overlap.
//   Note FSM, states N0 -> N1 -> N2 -> N3 -> N0:
//   - arp_en=1: note_tmr counts 0..NOTE_HOLD-1. On its wrap the note advances one state.
//   - arp_en=0: the next edge forces note=N0 and note_tmr=0. The note stays N0 while arp_en=0.
//   - On an arp_en 0->1 transition, the sequence starts at N0 with note_tmr=0. The first advance is after NOTE_HOLD clocks.
//   - A note change never resets bram_addr, so the waveform phase is continuous.
//   Simultaneous events:
//   - Note advance and step wrap on the same edge: the wrap latches P of the OLD note; the new note applies from the following step.
//   - arp_en falling on a note_tmr wrap edge: forcing to N0 wins.
//   Reset mid-operation:
//   - An in-flight BRAM read is discarded. sample_valid must not pulse after reset release for that read.
// TESTING
//   Use NOTE_HOLD=16 and BRAM_LAT=1 unless stated otherwise.
//   1. Reset, arp_en=0, sw=0:
//      - bram_en pulses every 746 clocks.
//      - bram_addr goes 1,2,3...
//      - sample_valid pulses 2 clocks after each bram_en.
//   2. sw=255, arp_en=0:
//      - Period is 1001. It must not be 489 (checks the 10-bit width).
//      - After 256 steps, bram_addr wraps 255 -> 0.
//   3. sw=0, arp_en=1, NOTE_HOLD=3000:
//      - note goes 0,1,2,3,0 every 3000 clocks.
//      - Step periods are 746, 597, 498, 373 respectively, each effective from the first step after the change.
//   4. Drop arp_en to 0 while note=2:
//      - note=0 one clock later and bram_addr continues incrementing.
//      - On re-enable, note holds 0 for NOTE_HOLD clocks.
//   5. BRAM model returns addr-tagged data with BRAM_LAT=3:
//      - sample equals the value of the address issued.
//      - sample_valid arrives 4 clocks after bram_en.
//   6. Assert CPU_RESETN=0 between a bram_en and its sample_valid:
//      - All outputs are 0 immediately (asynchronous).
//      - There is no stray sample_valid after release.

Source files
------------

// File: rtl/arp_wavetable_sequencer.sv
// -----------------------------------------------------------------------------
// arp_wavetable_sequencer
//
// Steps the sine-wavetable BRAM read address at a rate set by the switches,
// captures each BRAM sample for the PWM stage, and optionally arpeggiates
// through four notes (root, major third, fifth, octave).
//
// Ports
//   CLK100MHZ    in   1       system clock
//   CPU_RESETN   in   1       asynchronous active-low reset
//   arp_en       in   1       level; 1 = arpeggiate, 0 = hold root note
//   sw           in   8       pitch select; larger value = lower pitch
//   bram_en      out  1       BRAM read enable, one-cycle pulse per step
//   bram_addr    out  ADDR_W  BRAM read address (wraps, never reset by notes)
//   bram_dout    in   DATA_W  BRAM read data, valid BRAM_LAT clocks after bram_en
//   sample       out  DATA_W  held sample to PWM
//   sample_valid out  1       one-cycle pulse when sample updates
//   note         out  2       current note index
// -----------------------------------------------------------------------------
module arp_wavetable_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 11,
    parameter int BASE_OFFSET = 746,
    parameter int NOTE_HOLD   = 50_000_000,
    parameter int BRAM_LAT    = 1
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic              arp_en,
    input  logic [7:0]        sw,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic [1:0]        note
);

    // Step periods span 373..1001 clocks, so 10 bits cover every counter.
    localparam int P_W   = 10;
    localparam int TMR_W = $clog2(NOTE_HOLD);

    typedef enum logic [1:0] {
        N0 = 2'd0,
        N1 = 2'd1,
        N2 = 2'd2,
        N3 = 2'd3
    } note_state_t;

    // ------------------------------------------------------------------
    // Step period selection
    // ------------------------------------------------------------------
    logic [P_W-1:0] w_div_base;
    logic [P_W-1:0] w_p_major3;
    logic [P_W-1:0] w_p_fifth;
    logic [P_W-1:0] w_p_octave;
    logic [P_W-1:0] w_p_sel;
    logic [P_W-1:0] w_p_eff;
    logic           w_step_last;

    note_state_t    r_state;
    note_state_t    w_state_nxt;
    logic [TMR_W-1:0] r_note_tmr;
    logic [TMR_W-1:0] w_tmr_nxt;

    logic [P_W-1:0]    r_step_cnt;
    logic [P_W-1:0]    r_p_lat;
    logic              r_p_loaded;
    logic              r_bram_en;
    logic [ADDR_W-1:0] r_bram_addr;

    logic [BRAM_LAT-1:0] r_lat_pipe;
    logic [DATA_W-1:0]   r_sample;
    logic                r_sample_valid;

    // Root period is kept at full 10 bits; 746+255 would alias if narrowed.
    assign w_div_base = P_W'(BASE_OFFSET) + {2'b00, sw};

    // Ratios are 8-bit fixed point: 205/256 ~ 4/5, 171/256 ~ 2/3.
    assign w_p_major3 = P_W'((18'(w_div_base) * 18'd205) >> 8);
    assign w_p_fifth  = P_W'((18'(w_div_base) * 18'd171) >> 8);
    assign w_p_octave = w_div_base >> 1;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_p_sel = w_div_base;
        case (r_state)
            N1:      w_p_sel = w_p_major3;
            N2:      w_p_sel = w_p_fifth;
            N3:      w_p_sel = w_p_octave;
            default: w_p_sel = w_div_base;
        endcase
    end

    // The very first step after reset has no latched period yet; it uses the
    // live selection, which is frozen into r_p_lat on the first clock.
    assign w_p_eff     = r_p_loaded ? r_p_lat : w_p_sel;
    assign w_step_last = (r_step_cnt == w_p_eff - P_W'(1));

    // ------------------------------------------------------------------
    // Step timer and address generator
    // ------------------------------------------------------------------
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_step_cnt  <= '0;
            r_p_lat     <= '0;
            r_p_loaded  <= 1'b0;
            r_bram_en   <= 1'b0;
            r_bram_addr <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // block sees the pre-edge values regardless of evaluation order.
            r_bram_en <= 1'b0;
            if (!r_p_loaded) begin
                r_p_loaded <= 1'b1;
                r_p_lat    <= w_p_sel;
            end
            if (w_step_last) begin
                // Latching here uses the pre-edge note, so a note change on
                // this same edge only applies from the following step.
                r_step_cnt  <= '0;
                r_p_lat     <= w_p_sel;
                r_bram_addr <= r_bram_addr + ADDR_W'(1);
                r_bram_en   <= 1'b1;
            end else begin
                r_step_cnt <= r_step_cnt + P_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample capture: a shift register tracks the read through the BRAM.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            // NOTE: the latency pipe is reset so a read in flight at reset
            // can never produce a sample_valid after release.
            r_lat_pipe     <= '0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_lat_pipe     <= BRAM_LAT'({r_lat_pipe, r_bram_en});
            r_sample_valid <= r_lat_pipe[BRAM_LAT-1];
            if (r_lat_pipe[BRAM_LAT-1]) begin
                r_sample <= bram_dout;
            end
        end
    end

    // ------------------------------------------------------------------
    // Note FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state    <= N0;
            r_note_tmr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_note_tmr <= w_tmr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_note_tmr;
        if (!arp_en) begin
            // Disabling takes priority over a timer wrap on the same edge.
            w_state_nxt = N0;
            w_tmr_nxt   = '0;
        end else if (r_note_tmr == TMR_W'(NOTE_HOLD - 1)) begin
            w_tmr_nxt = '0;
            case (r_state)
                N0:      w_state_nxt = N1;
                N1:      w_state_nxt = N2;
                N2:      w_state_nxt = N3;
                default: w_state_nxt = N0;
            endcase
        end else begin
            w_tmr_nxt = r_note_tmr + TMR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bram_en      = r_bram_en;
    assign bram_addr    = r_bram_addr;
    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign note         = r_state;

endmodule

// File: tb/tb_arp_wavetable_sequencer.sv
// -----------------------------------------------------------------------------
// tb_arp_wavetable_sequencer
//
// Three instances share one clock:
//   u_a  NOTE_HOLD=16,   BRAM_LAT=1  : basic stepping, sw width, arp drop, reset
//   u_b  NOTE_HOLD=3000, BRAM_LAT=1  : full arpeggio period sequence
//   u_c  BASE_OFFSET=0, sw=10, BRAM_LAT=3 : address-tagged latency and wrap
// Each BRAM model returns an address tag only in the cycle the read data is
// due, and all-ones otherwise.
// -----------------------------------------------------------------------------
module tb_arp_wavetable_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    function automatic logic [10:0] bram_tag(input logic [7:0] a);
        return {3'b101, a};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- instance A ----------------
    logic        rst_a, arp_a, en_a, vld_a;
    logic [7:0]  sw_a, addr_a;
    logic [10:0] dout_a, smp_a;
    logic [1:0]  note_a;

    arp_wavetable_sequencer #(.NOTE_HOLD(16), .BRAM_LAT(1)) u_a (
        .CLK100MHZ(clk), .CPU_RESETN(rst_a), .arp_en(arp_a), .sw(sw_a),
        .bram_en(en_a), .bram_addr(addr_a), .bram_dout(dout_a),
        .sample(smp_a), .sample_valid(vld_a), .note(note_a)
    );

    always @(posedge clk) dout_a <= en_a ? bram_tag(addr_a) : 11'h7FF;

    // ---------------- instance B ----------------
    logic        rst_b, arp_b, en_b, vld_b;
    logic [7:0]  sw_b, addr_b;
    logic [10:0] dout_b, smp_b;
    logic [1:0]  note_b;

    arp_wavetable_sequencer #(.NOTE_HOLD(3000), .BRAM_LAT(1)) u_b (
        .CLK100MHZ(clk), .CPU_RESETN(rst_b), .arp_en(arp_b), .sw(sw_b),
        .bram_en(en_b), .bram_addr(addr_b), .bram_dout(dout_b),
        .sample(smp_b), .sample_valid(vld_b), .note(note_b)
    );

    always @(posedge clk) dout_b <= en_b ? bram_tag(addr_b) : 11'h7FF;

    // ---------------- instance C ----------------
    logic        rst_c, arp_c, en_c, vld_c;
    logic [7:0]  sw_c, addr_c;
    logic [10:0] dout_c, smp_c, c1, c2;
    logic [1:0]  note_c;

    arp_wavetable_sequencer #(.BASE_OFFSET(0), .NOTE_HOLD(16), .BRAM_LAT(3)) u_c (
        .CLK100MHZ(clk), .CPU_RESETN(rst_c), .arp_en(arp_c), .sw(sw_c),
        .bram_en(en_c), .bram_addr(addr_c), .bram_dout(dout_c),
        .sample(smp_c), .sample_valid(vld_c), .note(note_c)
    );

    always @(posedge clk) begin
        c1     <= en_c ? bram_tag(addr_c) : 11'h7FF;
        c2     <= c1;
        dout_c <= c2;
    end

    // Waits (bounded) for bram_en of the selected instance at a negedge.
    task automatic wait_en(input int sel, output int t);
        int   n   = 0;
        logic hit = 1'b0;
        while (!hit && n < 2000) begin
            @(negedge clk);
            n++;
            case (sel)
                0:       hit = en_a;
                1:       hit = en_b;
                default: hit = en_c;
            endcase
        end
        if (!hit) check($sformatf("timeout_en%0d", sel), 32'd0, 32'd1);
        t = cyc;
    endtask

    int exp_iv[24] = '{746, 746, 746, 746, 746,
                       597, 597, 597, 597,
                       498, 498, 498, 498, 498, 498,
                       373, 373, 373, 373, 373, 373, 373, 373,
                       746};

    initial begin
        int t;
        int t0;
        int n;
        int cnt;

        rst_a = 1'b0; arp_a = 1'b0; sw_a = 8'd0;
        rst_b = 1'b0; arp_b = 1'b0; sw_b = 8'd0;
        rst_c = 1'b0; arp_c = 1'b0; sw_c = 8'd10;
        repeat (3) @(negedge clk);

        // ---------------- reset state ----------------
        check("rst_en_a",   en_a,   0);
        check("rst_addr_a", addr_a, 0);
        check("rst_smp_a",  smp_a,  0);
        check("rst_vld_a",  vld_a,  0);
        check("rst_note_a", note_a, 0);
        check("rst_addr_c", addr_c, 0);

        // ---------------- test 1: sw=0, root period 746 ----------------
        rst_a = 1'b1;
        t0 = cyc;
        for (int i = 1; i <= 3; i++) begin
            wait_en(0, t);
            check("t1_period", t - t0, 746);
            t0 = t;
            check("t1_addr", addr_a, i);
            @(negedge clk);
            check("t1_vld_early", vld_a, 0);
            @(negedge clk);
            check("t1_vld", vld_a, 1);
            check("t1_sample", smp_a, bram_tag(8'(i)));
        end

        // ---------------- test 2: sw=255 mid-step, then 1001 ----------------
        sw_a = 8'd255;
        for (int i = 4; i <= 6; i++) begin
            wait_en(0, t);
            check("t2_period", t - t0, (i == 4) ? 746 : 1001);
            t0 = t;
            check("t2_addr", addr_a, i);
        end

        // ---------------- test 4: arp drop at note 2 ----------------
        rst_a = 1'b0;
        @(negedge clk);
        sw_a  = 8'd0;
        arp_a = 1'b1;
        rst_a = 1'b1;
        t0 = cyc;
        repeat (16) @(negedge clk);
        check("t4_note1", note_a, 1);
        repeat (16) @(negedge clk);
        check("t4_note2", note_a, 2);
        arp_a = 1'b0;
        @(negedge clk);
        check("t4_forced_n0", note_a, 0);
        wait_en(0, t);
        check("t4_period", t - t0, 746);
        t0 = t;
        check("t4_addr1", addr_a, 1);
        wait_en(0, t);
        check("t4_period2", t - t0, 746);
        check("t4_addr2", addr_a, 2);

        // arp_en falls exactly on the timer-wrap edge: forcing to N0 wins
        arp_a = 1'b1;
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (note_a != 2'd0) cnt++;
        end
        check("t4_hold_before_wrap", cnt, 0);
        arp_a = 1'b0;
        @(negedge clk);
        check("t4_force_wins", note_a, 0);

        // re-enable: note holds N0 for exactly NOTE_HOLD clocks
        arp_a = 1'b1;
        n = 0;
        while (note_a == 2'd0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t4_reenable_hold", n, 16);
        check("t4_reenable_note", note_a, 1);

        // ---------------- test 6: reset between bram_en and sample_valid ----
        arp_a = 1'b0;
        wait_en(0, t);
        @(negedge clk);
        check("t6_pre_smp_nonzero", (smp_a != 11'd0), 1);
        rst_a = 1'b0;
        #1;
        check("t6_en",   en_a,   0);
        check("t6_addr", addr_a, 0);
        check("t6_smp",  smp_a,  0);
        check("t6_vld",  vld_a,  0);
        check("t6_note", note_a, 0);
        #1;
        rst_a = 1'b1;
        t0 = cyc;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (vld_a) cnt++;
        end
        check("t6_no_stray_vld", cnt, 0);
        wait_en(0, t);
        check("t6_restart_period", t - t0, 746);
        check("t6_restart_addr", addr_a, 1);

        // ---------------- test 3: arpeggio periods (NOTE_HOLD=3000) ----------
        arp_b = 1'b1;
        rst_b = 1'b1;
        fork
            begin
                int tb;
                int tp;
                tp = cyc;
                for (int i = 0; i < 24; i++) begin
                    wait_en(1, tb);
                    check($sformatf("t3_iv%0d", i), tb - tp, exp_iv[i]);
                    tp = tb;
                end
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    repeat (2999) @(negedge clk);
                    check("t3_note_before", note_b, i);
                    @(negedge clk);
                    check("t3_note_after", note_b, (i + 1) % 4);
                end
            end
        join

        // ---------------- test 5: BRAM_LAT=3, tagged data, address wrap -------
        rst_c = 1'b1;
        t0 = cyc;
        for (int i = 1; i <= 4; i++) begin
            wait_en(2, t);
            check("t5_period", t - t0, 10);
            t0 = t;
            check("t5_addr", addr_c, i);
            cnt = 0;
            repeat (3) begin
                @(negedge clk);
                if (vld_c) cnt++;
            end
            check("t5_vld_early", cnt, 0);
            @(negedge clk);
            check("t5_vld", vld_c, 1);
            check("t5_sample", smp_c, bram_tag(8'(i)));
        end
        for (int i = 5; i <= 256; i++) begin
            wait_en(2, t);
            if (i >= 255) check("t5_wrap_addr", addr_c, i % 256);
        end
        repeat (4) @(negedge clk);
        check("t5_wrap_vld", vld_c, 1);
        check("t5_wrap_sample", smp_c, bram_tag(8'd0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
